// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - trellis constants and code definition for the K=3, rate-1/2 (7,5) code
package viterbi_pkg;

  localparam int         K          = 3;
  localparam int         NUM_STATES = 4;
  localparam logic [2:0] G0         = 3'b111;
  localparam logic [2:0] G1         = 3'b101;

  typedef logic [1:0] state_t;

  // Shift register is {b, s[1], s[0]}; result is {g0 bit, g1 bit}.
  function automatic logic [1:0] code_bits(input state_t s, input logic b);
    logic [K-1:0] sr;
    sr = {b, s};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// rtl/viterbi_acs.sv - one add-compare-select butterfly: preds {X,0},{X,1} -> next states {0,X},{1,X}
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W   = 8,
  parameter int TB_LEN = 16,
  parameter bit X      = 1'b0
) (
  input  logic [1:0]        d_in,
  input  logic [PM_W-1:0]   pm_a,
  input  logic [PM_W-1:0]   pm_b,
  input  logic [TB_LEN-1:0] surv_a,
  input  logic [TB_LEN-1:0] surv_b,
  output logic [PM_W-1:0]   pm_new [2],
  output logic [TB_LEN-1:0] surv_new [2]
);

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_branch
    localparam logic B = 1'(g);
    logic [PM_W-1:0]   cand_a;
    logic [PM_W-1:0]   cand_b;
    logic [TB_LEN-1:0] sel_surv;
    logic              take_b;

    assign cand_a = sat_add(pm_a, hamming(d_in, code_bits({X, 1'b0}, B)));
    assign cand_b = sat_add(pm_b, hamming(d_in, code_bits({X, 1'b1}, B)));
    // Strict compare: ties resolve to the predecessor whose s[0] is 0.
    assign take_b       = cand_b < cand_a;
    assign pm_new[g]    = take_b ? cand_b : cand_a;
    assign sel_surv     = take_b ? surv_b : surv_a;
    assign surv_new[g]  = (sel_surv << 1) | TB_LEN'(B);
  end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// rtl/viterbi_decoder_k3.sv - hard-decision register-exchange Viterbi decoder for the K=3 (7,5) code
module viterbi_decoder_k3
  import viterbi_pkg::*;
#(
  parameter int TB_LEN = 16,
  parameter int PM_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  localparam int              CNT_W   = $clog2(TB_LEN);
  localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

  logic [PM_W-1:0]   metric_q [NUM_STATES];
  logic [TB_LEN-1:0] surv_q   [NUM_STATES];
  logic [CNT_W-1:0]  sym_cnt_q;

  logic [PM_W-1:0]   bf0_pm   [2];
  logic [PM_W-1:0]   bf1_pm   [2];
  logic [TB_LEN-1:0] bf0_surv [2];
  logic [TB_LEN-1:0] bf1_surv [2];
  logic [PM_W-1:0]   acs_pm   [NUM_STATES];
  logic [TB_LEN-1:0] acs_surv [NUM_STATES];
  logic [PM_W-1:0]   min_pm;
  state_t            best;
  logic              filled;

  viterbi_acs #(.PM_W(PM_W), .TB_LEN(TB_LEN), .X(1'b0)) u_acs_x0 (
    .d_in     (d_in),
    .pm_a     (metric_q[0]),
    .pm_b     (metric_q[1]),
    .surv_a   (surv_q[0]),
    .surv_b   (surv_q[1]),
    .pm_new   (bf0_pm),
    .surv_new (bf0_surv)
  );

  viterbi_acs #(.PM_W(PM_W), .TB_LEN(TB_LEN), .X(1'b1)) u_acs_x1 (
    .d_in     (d_in),
    .pm_a     (metric_q[2]),
    .pm_b     (metric_q[3]),
    .surv_a   (surv_q[2]),
    .surv_b   (surv_q[3]),
    .pm_new   (bf1_pm),
    .surv_new (bf1_surv)
  );

  // Next state {b, x}: butterfly x=0 feeds states 0/2, x=1 feeds states 1/3.
  assign acs_pm[0]   = bf0_pm[0];
  assign acs_pm[2]   = bf0_pm[1];
  assign acs_pm[1]   = bf1_pm[0];
  assign acs_pm[3]   = bf1_pm[1];
  assign acs_surv[0] = bf0_surv[0];
  assign acs_surv[2] = bf0_surv[1];
  assign acs_surv[1] = bf1_surv[0];
  assign acs_surv[3] = bf1_surv[1];

  always_comb begin
    min_pm = acs_pm[0];
    best   = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (acs_pm[s] < min_pm) begin
        min_pm = acs_pm[s];
        best   = state_t'(s);
      end
    end
  end

  assign filled = (sym_cnt_q == CNT_W'(TB_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        metric_q[s] <= (s == 0) ? '0 : PM_INIT;
        surv_q[s]   <= '0;
      end
      sym_cnt_q <= '0;
      d_out     <= 1'b0;
    end else if (enable) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        metric_q[s] <= acs_pm[s] - min_pm;
        surv_q[s]   <= acs_surv[s];
      end
      if (!filled) begin
        sym_cnt_q <= sym_cnt_q + 1'b1;
      end
      d_out <= filled & acs_surv[best][TB_LEN-1];
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// tb/tb_viterbi_decoder_k3.sv - directed self-checking bench for viterbi_decoder_k3
module tb_viterbi_decoder_k3;

  localparam int TB_LEN = 16;
  localparam int PM_W   = 8;
  localparam int N      = 256;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] d_in   = 2'b00;
  logic       d_out;

  int errs   = 0;
  int checks = 0;
  int n_flips;

  logic       src [N];
  logic [1:0] rx  [N];
  logic       dec [N];

  viterbi_decoder_k3 #(.TB_LEN(TB_LEN), .PM_W(PM_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d_in   (d_in),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expd);
    end
  endtask

  function automatic logic [1:0] enc_sym(input logic [1:0] s, input logic b);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  task automatic check_reset_metrics(input string tag);
    check({tag, "_m0"}, 32'(dut.metric_q[0]), 32'd0);
    check({tag, "_m1"}, 32'(dut.metric_q[1]), 32'd128);
    check({tag, "_m2"}, 32'(dut.metric_q[2]), 32'd128);
    check({tag, "_m3"}, 32'(dut.metric_q[3]), 32'd128);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b0;
    d_in   = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // mode 0 clean, 1 single d_in[0] flip at i%32==5, 2 burst at i%32 in 29..31
  task automatic encode_stream(input int n, input int mode);
    logic [1:0] st;
    st      = 2'b00;
    n_flips = 0;
    for (int i = 0; i < n; i++) begin
      rx[i] = enc_sym(st, src[i]);
      st    = {src[i], st[1]};
      if ((mode == 1 && i % 32 == 5) || (mode == 2 && i % 32 >= 29)) begin
        rx[i][0] = ~rx[i][0];
        if (i < n - TB_LEN + 1) n_flips++;
      end
    end
  endtask

  task automatic feed(input int n, input bit gaps, input bit partial, input string tag);
    int j;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 6 && $urandom_range(1) == 1; g++) begin
          enable = 1'b0;
          d_in   = 2'($urandom_range(3));
          @(posedge clk);
          #1 check({tag, "_hold"}, 32'(d_out), (i >= TB_LEN) ? 32'(src[i-TB_LEN]) : 32'd0);
        end
      end
      enable = 1'b1;
      d_in   = rx[i];
      @(posedge clk);
      #1;
      if (i < TB_LEN - 1) begin
        check({tag, "_fill"}, 32'(d_out), 32'd0);
      end else begin
        j      = i - TB_LEN + 1;
        dec[j] = d_out;
        if (!partial || (j % 32) <= 20) check(tag, 32'(d_out), 32'(src[j]));
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    int          mism;
    logic [1:0]  st;
    logic [1:0]  kv_sym [6];
    logic        kv_bit [6];

    kv_sym = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    kv_bit = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 check("rst_dout", 32'(d_out), 32'd0);
    check_reset_metrics("rst");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_in = 2'($urandom_range(3));
      @(posedge clk);
      #1 check("idle_dout", 32'(d_out), 32'd0);
    end
    check_reset_metrics("idle");

    do_reset();
    for (int i = 0; i < 6 + TB_LEN; i++) begin
      src[i] = (i < 6) ? kv_bit[i] : 1'b0;
      rx[i]  = (i < 6) ? kv_sym[i] : 2'b00;
    end
    feed(6 + TB_LEN, 1'b0, 1'b0, "known");

    for (int i = 0; i < N; i++) src[i] = 1'($urandom_range(1));
    do_reset();
    encode_stream(N, 0);
    feed(N, 1'b0, 1'b0, "clean");

    do_reset();
    encode_stream(N, 1);
    feed(N, 1'b0, 1'b0, "single");
    mism = 0;
    st   = 2'b00;
    for (int j = 0; j < N - TB_LEN + 1; j++) begin
      logic [1:0] diff;
      diff = enc_sym(st, dec[j]) ^ rx[j];
      mism += int'(diff[1]) + int'(diff[0]);
      st   = {dec[j], st[1]};
    end
    check("flip_count", 32'(mism), 32'(n_flips));
    check("flip_expected", 32'(mism), 32'd8);

    do_reset();
    encode_stream(N, 2);
    feed(N, 1'b0, 1'b1, "burst");

    do_reset();
    encode_stream(N, 0);
    feed(N, 1'b1, 1'b0, "gap");

    do_reset();
    for (int i = 0; i < 40; i++) src[i] = 1'b1;
    encode_stream(40, 0);
    feed(40, 1'b0, 1'b0, "ones");
    check("pre_rst_dout", 32'(d_out), 32'd1);
    #2 rst = 1'b0;
    #1 check("async_rst_dout", 32'(d_out), 32'd0);
    check_reset_metrics("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 100; i++) src[i] = 1'($urandom_range(1));
    encode_stream(100, 0);
    feed(100, 1'b0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
